register_dump_tx: RTL and testbench
===================================

// Module: register_dump_tx
// PURPOSE
// - Debug read-out engine on the register-file read side: on command, walks every register
//   via the reg_1 read port and shifts each value out as a serial frame on one output pin.
// - Sits beside registers in the top level; owns reg_1_out_sel while busy, idle otherwise.
// - Gives the bench and the chip a pin-level dump of CPU state without extra read ports.
// PARAMETERS
// - DATA_BUS_WIDTH  8  width of one register / data bits per frame
// - NUM_REGS        4  registers dumped, indices 0..NUM_REGS-1
// - SEL_WIDTH       2  width of the register select, >= clog2(NUM_REGS)
// - BIT_CYCLES      4  clock cycles per serial bit, >= 1
// PORTS
// - clock         in   1               system clock, rising edge
// - reset         in   1               asynchronous, active-high
// - start         in   1               start-dump request, sampled in IDLE only
// - abort         in   1               cancel dump in progress
// - reg_data      in   DATA_BUS_WIDTH  value from registers reg_1_out
// - dump_sel      out  SEL_WIDTH       drives registers reg_1_out_sel while busy
// - busy          out  1               high from the edge after start until done
// - done          out  1               one-cycle pulse after the last stop bit
// - ser_out       out  1               serial line, idle high, registered
// BEHAVIOUR
// - Reset (async): state IDLE, ser_out=1, busy=0, done=0, dump_sel=0, counters cleared.
// - States: IDLE -> SELECT -> LOAD -> START_BIT -> DATA -> [PARITY] -> STOP -> SELECT | FINISH -> IDLE.
// - IDLE: start=1 at an edge -> SELECT, busy=1, reg index=0. start ignored in other states.
// - SELECT (1 cycle): dump_sel=index; register read is combinational, settles this cycle.
// - LOAD (1 cycle): shift reg <= reg_data; on the same edge ser_out <= 0 (start bit begins).
// - START_BIT: ser_out=0 for BIT_CYCLES cycles.
// - DATA: DATA_BUS_WIDTH bits, MSB first, each held BIT_CYCLES cycles.
// - STOP: ser_out=1 for BIT_CYCLES cycles; then index==NUM_REGS-1 ? FINISH : index+1, SELECT.
// - FINISH (1 cycle): done=1, busy=0 on the same edge; next edge -> IDLE. done never held >1 cycle.
// - Per-register cost: 2 + BIT_CYCLES*(DATA_BUS_WIDTH+2) cycles (+BIT_CYCLES with parity).
// - Bit-period counter counts 0..BIT_CYCLES-1, wraps per bit; index never exceeds NUM_REGS-1.
// - dump_sel holds the current index from SELECT through STOP; it returns to 0 in IDLE.
// - abort=1 at any edge while busy: -> IDLE next edge, ser_out=1, busy=0, no done pulse.
//   A truncated frame is legal on the line. abort in IDLE does nothing; abort beats start.
// - Reset mid-frame: line forced high immediately (async), no done pulse.
// - reg_data changing after LOAD does not affect the frame in flight.
// - Back-to-back: start high during FINISH is ignored; a new dump needs start in IDLE.
// CONFIGURATION
// - DUMP_PARITY_EN defined: PARITY state between DATA and STOP; ser_out = XOR of the data
//   bits (even parity) for BIT_CYCLES cycles; per-register cost grows by BIT_CYCLES.
// - DUMP_PARITY_EN undefined: no PARITY state; frame = start + data + stop.
// TESTING
// - Regs {0xA5,0x3C,0xFF,0x00}, BIT_CYCLES=4, start pulse -> line decodes 0xA5,0x3C,0xFF,0x00
//   in order; done pulses exactly once, 168 cycles after the start edge (no parity).
// - Check dump_sel = 0,1,2,3 while each frame is sent and = 0 in IDLE; busy high through all
//   4 frames and low on the done cycle.
// - abort during DATA of register 1 -> IDLE on next edge, ser_out=1, no done; a new start
//   then dumps all 4 regs from index 0.
// - Reset asserted mid start bit -> ser_out=1, busy=0 without waiting for a clock edge;
//   start pulses while busy -> no effect on frame count or timing.
// - Change reg_data of the current register one cycle after LOAD -> the frame still carries
//   the value captured at LOAD.
// - With DUMP_PARITY_EN: 0xA5 -> parity 0, 0x3C -> 0, 0xFF -> 0, 0x01 -> 1; frame is 11 bits;
//   total time is 4*(2+44) = 184 cycles.

Source files
------------

// File: rtl/register_dump_tx.sv
// register_dump_tx: walks the register file through the reg_1 read port and shifts each
// register out on one pin as a serial frame: start(0), data MSB first, [parity], stop(1).
// Optional build macro: DUMP_PARITY_EN adds an even-parity bit between data and stop.
module register_dump_tx #(
    parameter int unsigned DATA_BUS_WIDTH = 8,
    parameter int unsigned NUM_REGS       = 4,
    parameter int unsigned SEL_WIDTH      = 2,
    parameter int unsigned BIT_CYCLES     = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DATA_BUS_WIDTH-1:0] reg_data,
    output logic [SEL_WIDTH-1:0]      dump_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      ser_out
);

    localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned IDX_W = (DATA_BUS_WIDTH > 1) ? $clog2(DATA_BUS_WIDTH) : 1;
    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]     BIT_LAST = IDX_W'(DATA_BUS_WIDTH - 1);
    localparam logic [SEL_WIDTH-1:0] REG_LAST = SEL_WIDTH'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        StIdle, StSelect, StLoad, StStart, StData, StParity, StStop, StFinish
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [SEL_WIDTH-1:0]      index_q, index_d;
    logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d;
    logic                      ser_q, ser_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
`ifdef DUMP_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    logic             bit_tick;
    logic [CNT_W-1:0] cnt_next;

    // Bit-period counter wraps at BIT_CYCLES-1; bit_tick marks the last cycle of a bit.
    assign bit_tick = (bit_cnt_q == CNT_MAX);
    assign cnt_next = bit_tick ? '0 : bit_cnt_q + CNT_W'(1);

    // The read mux is only ours while busy; park it at register 0 otherwise.
    assign dump_sel = busy_q ? index_q : '0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ser_out  = ser_q;

    // Next-state and output logic for the dump sequencer.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        index_d   = index_q;
        shift_d   = shift_q;
        ser_d     = ser_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef DUMP_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            StIdle: begin
                ser_d   = 1'b1;
                index_d = '0;
                if (start) begin
                    state_d = StSelect;
                    busy_d  = 1'b1;
                end
            end
            // dump_sel already shows index_q; the register read settles this cycle.
            StSelect: state_d = StLoad;
            StLoad: begin
                shift_d   = reg_data;
`ifdef DUMP_PARITY_EN
                parity_d  = ^reg_data;
`endif
                ser_d     = 1'b0;
                bit_cnt_d = '0;
                state_d   = StStart;
            end
            StStart: begin
                bit_cnt_d = cnt_next;
                if (bit_tick) begin
                    ser_d     = shift_q[DATA_BUS_WIDTH-1];
                    shift_d   = shift_q << 1;
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                bit_cnt_d = cnt_next;
                if (bit_tick) begin
                    if (bit_idx_q == BIT_LAST) begin
`ifdef DUMP_PARITY_EN
                        ser_d   = parity_q;
                        state_d = StParity;
`else
                        ser_d   = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        ser_d     = shift_q[DATA_BUS_WIDTH-1];
                        shift_d   = shift_q << 1;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef DUMP_PARITY_EN
            StParity: begin
                bit_cnt_d = cnt_next;
                if (bit_tick) begin
                    ser_d   = 1'b1;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                bit_cnt_d = cnt_next;
                if (bit_tick) begin
                    if (index_q == REG_LAST) begin
                        state_d = StFinish;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        index_d = index_q + SEL_WIDTH'(1);
                        state_d = StSelect;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Abort wins over everything while busy; the partial frame is simply cut off.
        if (abort && busy_q) begin
            state_d = StIdle;
            ser_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            index_d = '0;
        end
    end

    // State and datapath registers; reset drives the line high at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            index_q   <= '0;
            shift_q   <= '0;
            ser_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef DUMP_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            index_q   <= index_d;
            shift_q   <= shift_d;
            ser_q     <= ser_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef DUMP_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_register_dump_tx.sv
// Bench for register_dump_tx: a UART-style receiver decodes the serial line and compares
// each frame, its select value and the done timing against expectations queued at start.
module tb_register_dump_tx;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int SW  = 2;
    localparam int BC  = 4;
    localparam int PER = 10;
`ifdef DUMP_PARITY_EN
    localparam int FB = DW + 3;
`else
    localparam int FB = DW + 2;
`endif
    localparam int DUMP_CYC = NR * (2 + BC * FB);

    logic          clock = 1'b0;
    logic          reset, start, abort;
    logic [DW-1:0] reg_data;
    logic [SW-1:0] dump_sel;
    logic          busy, done, ser_out;
    logic [DW-1:0] regs [NR];

    register_dump_tx #(
        .DATA_BUS_WIDTH(DW), .NUM_REGS(NR), .SEL_WIDTH(SW), .BIT_CYCLES(BC)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .reg_data(reg_data),
        .dump_sel(dump_sel), .busy(busy), .done(done), .ser_out(ser_out)
    );

    assign reg_data = regs[dump_sel];
    always #(PER / 2) clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];   // {register index, data byte}
    longint      done_q[$];  // expected time of the done sample

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // Monitor: decode frames mid-bit on the falling edge and score them.
    initial begin
        logic          rx_active = 1'b0;
        int            rx_cnt = 0;
        logic [FB-1:0] rx_bits = '0;
        logic          done_prev = 1'b0;
        logic [15:0]   e;
        forever begin
            @(negedge clock);
            if (done) begin
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done_time", longint'($time), done_q.pop_front());
                check("busy_on_done", longint'(busy), 0);
            end
            if (done_prev && done) check("done_width", 2, 1);
            done_prev = done;
            if (!busy && !reset) check("idle_sel", longint'(dump_sel), 0);

            if (!busy || reset) rx_active = 1'b0;
            else if (!rx_active && ser_out == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
            if (rx_active) begin
                if (rx_cnt % BC == BC / 2) begin
                    rx_bits[FB-1-rx_cnt/BC] = ser_out;
                    if (rx_cnt / BC == FB - 1) begin
                        rx_active = 1'b0;
                        if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
                        else begin
                            e = exp_q.pop_front();
                            check("frame_data", longint'(rx_bits[FB-2 -: DW]), longint'(e[7:0]));
                            check("frame_sel", longint'(dump_sel), longint'(e[15:8]));
                            check("start_bit", longint'(rx_bits[FB-1]), 0);
                            check("stop_bit", longint'(rx_bits[0]), 1);
`ifdef DUMP_PARITY_EN
                            check("parity_bit", longint'(rx_bits[1]), longint'(^e[7:0]));
`endif
                        end
                    end
                end
                rx_cnt++;
            end
        end
    end

    // Issue a start pulse from IDLE and queue the model's expectations.
    task automatic launch();
        longint t0;
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        t0 = longint'($time);
        for (int i = 0; i < NR; i++) exp_q.push_back({8'(i), regs[i]});
        done_q.push_back(t0 + longint'(DUMP_CYC * PER + PER / 2));
        #1 start = 1'b0;
        check("busy_after_start", longint'(busy), 1);
    endtask

    // Run until done, optionally spamming start and mutating the register just loaded.
    task automatic run_dump(input bit spam, input bit mutate);
        bit mutated [NR];
        bit seen = 1'b0;
        for (int i = 0; i < NR; i++) mutated[i] = 1'b0;
        launch();
        for (int n = 0; n < DUMP_CYC + 20 && !seen; n++) begin
            @(posedge clock);
            #1 start = spam && busy && ($urandom_range(0, 5) == 0);
            if (mutate && busy && ser_out == 1'b0 && !mutated[dump_sel]) begin
                regs[dump_sel] = 8'($urandom);
                mutated[dump_sel] = 1'b1;
            end
            @(negedge clock);
            seen = done;
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        repeat (3) @(posedge clock);
    endtask

    initial begin
        bit hit;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        regs[0] = 8'hA5; regs[1] = 8'h3C; regs[2] = 8'hFF; regs[3] = 8'h00;
        #12;
        check("rst_ser", longint'(ser_out), 1);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_sel", longint'(dump_sel), 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Reference vector, then with start spam and post-load data changes.
        run_dump(1'b0, 1'b0);
        run_dump(1'b1, 1'b1);

        // Abort during the data bits of register 1.
        launch();
        hit = 1'b0;
        for (int n = 0; n < DUMP_CYC && !hit; n++) begin
            @(negedge clock);
            hit = (dump_sel == SW'(1)) && (ser_out == 1'b0);
        end
        check("reach_reg1", longint'(hit), 1);
        repeat (BC * 3) @(posedge clock);
        #1 abort = 1'b1;
        exp_q.delete();
        done_q.delete();
        @(posedge clock);
        #1 abort = 1'b0;
        check("abort_ser", longint'(ser_out), 1);
        check("abort_busy", longint'(busy), 0);
        repeat (DUMP_CYC) @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        check("idle_abort_busy", longint'(busy), 0);
        for (int i = 0; i < NR; i++) regs[i] = 8'($urandom);
        run_dump(1'b0, 1'b0);

        // Asynchronous reset in the middle of a start bit.
        launch();
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clock);
            hit = (ser_out == 1'b0);
        end
        check("reach_start_bit", longint'(hit), 1);
        @(posedge clock);
        #2 reset = 1'b1;
        exp_q.delete();
        done_q.delete();
        #1;
        check("async_rst_ser", longint'(ser_out), 1);
        check("async_rst_busy", longint'(busy), 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Randomised dumps.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NR; i++) regs[i] = 8'($urandom);
            run_dump(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("frames_left", longint'(exp_q.size()), 0);
        check("dones_left", longint'(done_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(100000 * PER);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
